// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM block-transfer engine.
package ram_dma_pkg;
  localparam int   ADDR_W    = 13;
  localparam int   LEN_W     = 14;
  localparam int   RAM_BYTES = 8192;
  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  typedef enum logic [2:0] {IDLE, FILL, RD, WR, DONE} state_e;

  // Lengths beyond the RAM size mean "the whole RAM".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(RAM_BYTES)) ? LEN_W'(RAM_BYTES) : len;
  endfunction
endpackage

// File: rtl/ram_dma_if.sv
// Request handshake plus RAM bus of the DMA engine; master = DMA side.
interface ram_dma_if;
  import ram_dma_pkg::*;

  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic [7:0]        fill_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_w_en;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport master (
    input  start, mode, src_addr, dst_addr, length, fill_data, ram_dout,
    output busy, done, ram_address, ram_w_en, ram_din
  );

  modport slave (
    output start, mode, src_addr, dst_addr, length, fill_data, ram_dout,
    input  busy, done, ram_address, ram_w_en, ram_din
  );
endinterface

// File: rtl/ram_dma.sv
// Block FILL / COPY engine for the 8 KB system RAM. FILL writes 1 byte/clk,
// COPY alternates RD/WR for 2 clk/byte, strictly ascending with modulo wrap.
module ram_dma
  import ram_dma_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  ram_dma_if.master bus
);
  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_src, r_dst, r_last_addr, w_addr;
  logic [LEN_W-1:0]  r_cnt, w_len;
  logic [7:0]        r_fill, r_last_din, w_din;
  logic              w_busy, w_done, w_wen, w_last;

  assign w_len  = clamp_len(bus.length);
  assign w_last = (r_cnt == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Address/data hold their last driven value outside active cycles. In WR the
  // write data is the RAM's own registered read output, forwarded unchanged.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_wen  = 1'b0;
    w_addr = r_last_addr;
    w_din  = r_last_din;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_len == '0)                w_next = DONE;
          else if (bus.mode == MODE_COPY) w_next = RD;
          else                            w_next = FILL;
        end
      end
      FILL: begin
        w_busy = 1'b1;
        w_wen  = 1'b1;
        w_addr = r_dst;
        w_din  = r_fill;
        if (w_last) w_next = DONE;
      end
      RD: begin
        w_busy = 1'b1;
        w_addr = r_src;
        w_next = WR;
      end
      WR: begin
        w_busy = 1'b1;
        w_wen  = 1'b1;
        w_addr = r_dst;
        w_din  = bus.ram_dout;
        w_next = w_last ? DONE : RD;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_fill      <= '0;
      r_last_addr <= '0;
      r_last_din  <= '0;
    end else begin
      r_last_addr <= w_addr;
      r_last_din  <= w_din;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_src  <= bus.src_addr;
            r_dst  <= bus.dst_addr;
            r_cnt  <= w_len;
            r_fill <= bus.fill_data;
          end
        end
        FILL: begin
          r_dst <= r_dst + 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
        WR: begin
          r_src <= r_src + 1'b1;
          r_dst <= r_dst + 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.ram_w_en    = w_wen;
  assign bus.ram_address = w_addr;
  assign bus.ram_din     = w_din;
endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: RAM model with 1-cycle registered read, a per-cycle
// expectation queue built from transfer requests, and a byte-level memory model.
module tb_ram_dma;
  import ram_dma_pkg::*;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              wen;
    logic              copy;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] src;
    logic [7:0]        din;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_dma_if bus ();
  ram_dma dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0]        ram [RAM_BYTES];
  logic [7:0]        mm  [RAM_BYTES];
  logic [7:0]        rdq;
  logic              preload = 1'b0;
  logic              bd_we   = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [7:0]        bd_data = '0;
  logic [7:0]        seed    = '0;
  exp_t              q[$];
  int checks = 0, failures = 0, nwrites = 0, ndone = 0, nbusy = 0;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37) + (a >> 7)) ^ seed;
  endfunction

  function automatic exp_t mk(input logic b, input logic dn, input logic w, input logic c,
                              input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                              input logic [7:0] d);
    exp_t r;
    r.busy = b; r.done = dn; r.wen = w; r.copy = c; r.addr = a; r.src = s; r.din = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // RAM: registered read, read-before-write, plus bench backdoor writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < RAM_BYTES; a++) ram[a] <= init_val(a);
    end else if (bd_we) ram[bd_addr] <= bd_data;
    else if (bus.ram_w_en) ram[bus.ram_address] <= bus.ram_din;
    rdq <= ram[bus.ram_address];
  end
  assign bus.ram_dout = rdq;

  // Compare process: one expectation per cycle; empty queue means idle.
  initial begin
    exp_t       e;
    logic       rs;
    logic [7:0] xd;
    forever begin
      @(posedge clk);
      rs = rst_n;
      if (preload) begin
        for (int a = 0; a < RAM_BYTES; a++) mm[a] = init_val(a);
      end else if (bd_we) mm[bd_addr] = bd_data;
      #3;
      if (!rs) begin
        q.delete();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wen",  bus.ram_w_en, 0);
        chk("rst_addr", bus.ram_address, 0);
        chk("rst_din",  bus.ram_din, 0);
      end else begin
        e = '0;
        if (q.size() != 0) e = q.pop_front();
        chk("busy", bus.busy, e.busy);
        chk("done", bus.done, e.done);
        chk("wen",  bus.ram_w_en, e.wen);
        if (e.busy) chk("addr", bus.ram_address, e.addr);
        if (e.wen) begin
          xd = e.copy ? mm[e.src] : e.din;
          chk("din", bus.ram_din, xd);
          mm[e.addr] = xd;
        end
      end
      if (bus.ram_w_en) nwrites++;
      if (bus.busy)     nbusy++;
      if (bus.done)     ndone++;
    end
  end

  task automatic start_xfer(input logic m, input int s, input int d, input int len,
                            input logic [7:0] f);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src_addr = ADDR_W'(s); bus.dst_addr = ADDR_W'(d);
    bus.length = LEN_W'(len); bus.fill_data = f;
    @(posedge clk);
    n = (len > RAM_BYTES) ? RAM_BYTES : len;
    for (int i = 0; i < n; i++) begin
      if (m == MODE_FILL) q.push_back(mk(1, 0, 1, 0, ADDR_W'(d + i), '0, f));
      else begin
        q.push_back(mk(1, 0, 0, 0, ADDR_W'(s + i), '0, '0));
        q.push_back(mk(1, 0, 1, 1, ADDR_W'(d + i), ADDR_W'(s + i), '0));
      end
    end
    q.push_back(mk(0, 1, 0, 0, '0, '0, '0));
    #1;
    bus.start = 1'b0;
    bus.mode = ~m; bus.src_addr = ADDR_W'($urandom); bus.dst_addr = ADDR_W'($urandom);
    bus.length = LEN_W'($urandom); bus.fill_data = 8'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (q.size() != 0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk("timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic bdw(input int a, input logic [7:0] d);
    @(negedge clk); bd_we = 1'b1; bd_addr = ADDR_W'(a); bd_data = d;
    @(negedge clk); bd_we = 1'b0;
  endtask

  task automatic do_preload(input logic [7:0] s);
    @(negedge clk); seed = s; preload = 1'b1;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic memchk(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < RAM_BYTES; a++) if (ram[a] !== mm[a]) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int w0, d0, b0, bad, len;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.length = '0; bus.fill_data = '0;
    seed = 8'h5D; preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // FILL across the top-of-RAM wrap
    w0 = nwrites; d0 = ndone; b0 = nbusy;
    start_xfer(MODE_FILL, 0, 'h1FFE, 4, 8'hA5);
    wait_done();
    chk("wrap_writes", nwrites - w0, 4);
    chk("wrap_busy",   nbusy - b0, 4);
    chk("wrap_done",   ndone - d0, 1);
    chk("wrap_1ffe", ram[13'h1FFE], 8'hA5);
    chk("wrap_1fff", ram[13'h1FFF], 8'hA5);
    chk("wrap_0000", ram[0], 8'hA5);
    chk("wrap_0001", ram[1], 8'hA5);
    memchk("wrap_mem");

    // COPY of three bytes
    bdw('h100, 8'h11); bdw('h101, 8'h22); bdw('h102, 8'h33);
    w0 = nwrites; d0 = ndone; b0 = nbusy;
    start_xfer(MODE_COPY, 'h100, 'h200, 3, 8'h00);
    wait_done();
    chk("copy_busy",   nbusy - b0, 6);
    chk("copy_writes", nwrites - w0, 3);
    chk("copy_done",   ndone - d0, 1);
    chk("copy_200", ram['h200], 8'h11);
    chk("copy_201", ram['h201], 8'h22);
    chk("copy_202", ram['h202], 8'h33);
    chk("copy_src", {ram['h100], ram['h101], ram['h102]}, 24'h112233);
    memchk("copy_mem");

    // zero length: straight to DONE
    w0 = nwrites; d0 = ndone; b0 = nbusy;
    start_xfer(MODE_FILL, 0, 'h30, 0, 8'hEE);
    wait_done();
    chk("len0_writes", nwrites - w0, 0);
    chk("len0_busy",   nbusy - b0, 0);
    chk("len0_done",   ndone - d0, 1);

    // oversize length clamps to the whole RAM
    do_preload(8'hC3);
    w0 = nwrites; b0 = nbusy;
    start_xfer(MODE_FILL, 0, 'h0123, 'h3FFF, 8'h3C);
    wait_done();
    chk("clamp_writes", nwrites - w0, 8192);
    chk("clamp_busy",   nbusy - b0, 8192);
    bad = 0;
    for (int a = 0; a < RAM_BYTES; a++) if (ram[a] !== 8'h3C) bad++;
    chk("clamp_all", bad, 0);
    memchk("clamp_mem");

    // start while busy is ignored
    do_preload(8'h17);
    w0 = nwrites; d0 = ndone;
    start_xfer(MODE_FILL, 0, 'h40, 8, 8'h77);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.mode = MODE_COPY; bus.dst_addr = 13'h0500; bus.length = 14'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (5) @(posedge clk);
    chk("busy_writes", nwrites - w0, 8);
    chk("busy_done",   ndone - d0, 1);
    memchk("busy_mem");

    // reset in cycle 3 of a FILL of 10
    w0 = nwrites; d0 = ndone;
    start_xfer(MODE_FILL, 0, 'h300, 10, 8'h99);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_writes", nwrites - w0, 3);
    chk("rst_nodone", ndone - d0, 0);
    chk("rst_302", ram['h302], 8'h99);
    memchk("rst_mem");
    w0 = nwrites; d0 = ndone;
    start_xfer(MODE_FILL, 0, 'h300, 2, 8'h42);
    wait_done();
    chk("post_rst_writes", nwrites - w0, 2);
    chk("post_rst_done",   ndone - d0, 1);

    // overlapping copy replicates forward
    bdw('h10, 8'h5A);
    start_xfer(MODE_COPY, 'h10, 'h11, 4, 8'h00);
    wait_done();
    chk("ovl_11_14", {ram['h11], ram['h12], ram['h13], ram['h14]}, 32'h5A5A5A5A);
    memchk("ovl_mem");

    // random transfers
    for (int t = 0; t < 12; t++) begin
      len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      start_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 8191)),
                 int'($urandom_range(0, 8191)), len, 8'($urandom));
      wait_done();
    end
    memchk("rand_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
